// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The operands are split into STAGES slices, and each slice adds its bits in one pipeline stage.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);
  localparam int S  = WIDTH / STAGES;
  localparam int NG = S / 4;

  // Slice adder: 4-bit CLA groups, group carries from a two-level lookahead over the slice.
  function automatic logic [S:0] slice_add(input logic [S-1:0] x, input logic [S-1:0] y,
                                           input logic ci);
    logic [S-1:0]  g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          term;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = ci;
    for (int j = 1; j <= NG; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) term = term & gp[m];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {gc[NG], p ^ c};
  endfunction

  logic [STAGES-1:0] vld_q, vld_d, cy_q, cy_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              stall;

  assign stall      = vld_q[STAGES-1] & ~out_ready_i;
  assign in_ready_o = ~stall;

  always_comb begin
    logic [WIDTH-1:0] src_a, src_b, src_s;
    logic             src_c, src_v;
    logic [S:0]       r;
    int               pk;
    vld_d = '0;
    cy_d  = '0;
    ovf_d = 1'b0;
    src_a = '0;
    src_b = '0;
    src_s = '0;
    src_c = 1'b0;
    src_v = 1'b0;
    r     = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = '0;
      opa_d[k] = '0;
      opb_d[k] = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      pk = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src_a = a_i;
        src_b = sub_i ? ~b_i : b_i;
        src_c = sub_i | cin_i;
        src_s = '0;
        src_v = in_valid_i;
      end else begin
        src_a = opa_q[pk];
        src_b = opb_q[pk];
        src_c = cy_q[pk];
        src_s = sum_q[pk];
        src_v = vld_q[pk];
      end
      r                  = slice_add(src_a[k*S +: S], src_b[k*S +: S], src_c);
      vld_d[k]           = src_v;
      cy_d[k]            = r[S];
      sum_d[k]           = src_s;
      sum_d[k][k*S +: S] = r[S-1:0];
      opa_d[k]           = src_a;
      opb_d[k]           = src_b;
      // The last slice holds the result MSB, so overflow is resolved there and registered.
      if (k == STAGES - 1)
        ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (r[S-1] != src_a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign sum_o       = sum_q[STAGES-1];
  assign cout_o      = cy_q[STAGES-1];
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vectors on the 16/4 build, random sweep on the 8/1 and 32/2 builds.
module tb_cla_pipe_adder;
  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        sw_in_valid, sw_out_ready, sw_cin, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic        r8_in_ready, r8_out_valid, r8_cout, r8_ovf;
  logic [7:0]  r8_sum;
  logic        r32_in_ready, r32_out_valid, r32_cout, r32_ovf;
  logic [31:0] r32_sum;

  int checks = 0;
  int errors = 0;

  cla_pipe_adder #(.WIDTH(16), .STAGES(4)) u0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .sum_o(sum), .cout_o(cout), .ovf_o(ovf));

  cla_pipe_adder #(.WIDTH(8), .STAGES(1)) u1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(sw_in_valid), .in_ready_o(r8_in_ready),
    .a_i(sw_a[7:0]), .b_i(sw_b[7:0]), .cin_i(sw_cin), .sub_i(sw_sub),
    .out_valid_o(r8_out_valid), .out_ready_i(sw_out_ready), .sum_o(r8_sum),
    .cout_o(r8_cout), .ovf_o(r8_ovf));

  cla_pipe_adder #(.WIDTH(32), .STAGES(2)) u2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(sw_in_valid), .in_ready_o(r32_in_ready),
    .a_i(sw_a), .b_i(sw_b), .cin_i(sw_cin), .sub_i(sw_sub),
    .out_valid_o(r32_out_valid), .out_ready_i(sw_out_ready), .sum_o(r32_sum),
    .cout_o(r32_cout), .ovf_o(r32_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int i);
    a   = vt[i].a;
    b   = vt[i].b;
    cin = vt[i].cin;
    sub = vt[i].sub;
  endtask

  function automatic logic [19:0] exp_of(input int i);
    return {1'b1, vt[i].co, vt[i].ov, 1'b0, vt[i].s};
  endfunction

  function automatic logic [19:0] got_u0();
    return {out_valid, cout, ovf, 1'b0, sum};
  endfunction

  // Reference: a+b+cin, or a+~b+1 for subtract; result {ovf, cout, sum}.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
    logic [63:0] mask, t;
    logic [31:0] xe, ye, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    xe   = x & mask[31:0];
    ye   = sb ? (~y & mask[31:0]) : (y & mask[31:0]);
    t    = {32'd0, xe} + {32'd0, ye} + {63'd0, (sb ? 1'b1 : ci)};
    s    = t[31:0] & mask[31:0];
    co   = t[w];
    ov   = (xe[w-1] == ye[w-1]) && (s[w-1] != xe[w-1]);
    return {ov, co, s};
  endfunction

  logic [33:0] q8[$];
  logic [33:0] q32[$];

  initial begin
    int sent, got, stall_cnt, acc8, acc32;
    logic [33:0] e;
    vt[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[6] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[7] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_cin = 1'b0; sw_sub = 1'b0;
    sw_a = '0; sw_b = '0;

    // Reset held two cycles with operands presented.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout_ovf", {cout, ovf}, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_after_reset", out_valid, 0);
    end

    // Back-to-back stream of all table vectors.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        drive(c);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c < 11) chk("stream", got_u0(), exp_of(c - 3));
      else chk("stream_idle", out_valid, 0);
    end
    in_valid = 1'b0;

    // Backpressure: 3 stalled cycles once the first result shows.
    sent = 0; got = 0; stall_cnt = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      in_valid = (sent < 6);
      if (sent < 6) drive(sent);
      if (out_valid && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", got_u0(), exp_of(got));
      end else if (out_valid) begin
        chk("bp_out", got_u0(), exp_of(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_delivered", got, 6);
    chk("bp_accepted", sent, 6);
    chk("bp_stall_cycles", stall_cnt, 3);
    chk("bp_no_dup", out_valid, 0);

    // Mid-flight reset flushes everything in the pipe.
    @(negedge clk);
    drive(0); in_valid = 1'b1;
    @(negedge clk);
    drive(1);
    @(negedge clk);
    drive(2); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("flush_now", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_idle", out_valid, 0);
    end
    drive(7); in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 3) chk("post_reset_op", got_u0(), exp_of(7));
      else chk("post_reset_idle", out_valid, 0);
    end

    // Random sweep on the 8/1 and 32/2 builds, sharing one stimulus stream.
    acc8 = 0; acc32 = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (acc8 >= 1000 && acc32 >= 1000 && q8.size() == 0 && q32.size() == 0) break;
      @(negedge clk);
      if (acc8 >= 1000 && acc32 >= 1000) begin
        sw_in_valid  = 1'b0;
        sw_out_ready = 1'b1;
      end else begin
        sw_in_valid  = ($urandom_range(0, 3) != 0);
        sw_out_ready = ($urandom_range(0, 3) != 0);
      end
      sw_a   = $urandom;
      sw_b   = $urandom;
      sw_cin = $urandom_range(0, 1) == 1;
      sw_sub = $urandom_range(0, 2) == 0;
      #1;
      if (r8_out_valid && sw_out_ready) begin
        if (q8.size() == 0) chk("sweep8_extra", 1, 0);
        else begin
          e = q8.pop_front();
          chk("sweep8", {r8_ovf, r8_cout, 24'd0, r8_sum}, e);
        end
      end
      if (r32_out_valid && sw_out_ready) begin
        if (q32.size() == 0) chk("sweep32_extra", 1, 0);
        else begin
          e = q32.pop_front();
          chk("sweep32", {r32_ovf, r32_cout, r32_sum}, e);
        end
      end
      if (sw_in_valid && r8_in_ready) begin
        q8.push_back(ref_op(8, sw_a, sw_b, sw_cin, sw_sub));
        acc8++;
      end
      if (sw_in_valid && r32_in_ready) begin
        q32.push_back(ref_op(32, sw_a, sw_b, sw_cin, sw_sub));
        acc32++;
      end
    end
    chk("sweep8_accepted", (acc8 >= 1000), 1);
    chk("sweep32_accepted", (acc32 >= 1000), 1);
    chk("sweep8_drained", q8.size(), 0);
    chk("sweep32_drained", q32.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
